// File: rtl/vga_console_pkg.sv
// Geometry, control codes and FSM encoding shared by the text console and its bench.
package vga_console_pkg;

   localparam int ConsCols     = 39;
   localparam int ConsRows     = 13;
   localparam int ConsLastCell = 506;

   localparam logic [15:0] ConsBlank = 16'h0020;

   localparam logic [6:0] ChLF = 7'h0A;
   localparam logic [6:0] ChCR = 7'h0D;
   localparam logic [6:0] ChBS = 7'h08;
   localparam logic [6:0] ChFF = 7'h0C;

   typedef enum logic [1:0] {
      ConsIdle    = 2'd0,
      ConsClrLine = 2'd1,
      ConsClrAll  = 2'd2
   } cons_state_t;

   // Fits in 9 bits for every legal row: 12*39 + 38 = 506.
   function automatic logic [8:0] row_base(input logic [3:0] row);
      return 9'(row) * 9'(ConsCols);
   endfunction

endpackage

// File: rtl/vga_console_if.sv
// CPU character stream into the console: valid/ready handshake with char and colour payload.
interface vga_console_if;
   logic       in_valid;
   logic [6:0] in_char;
   logic [8:0] in_color;
   logic       in_ready;

   modport master (output in_valid, output in_char, output in_color, input in_ready);
   modport slave  (input in_valid, input in_char, input in_color, output in_ready);
endinterface

// File: rtl/vga_console.sv
// Text console: cursor, control codes and line/screen clear sweeps into VGA char memory.
// Write port registered (one cycle after accept); in_ready low while a sweep runs or a clear is pending.
module vga_console
   import vga_console_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   vga_console_if.slave        cpu,
   input  logic                clear,
   output logic                we,
   output logic [8:0]          mem_addr,
   output logic [15:0]         mem_data,
   output logic [3:0]          cursor_row,
   output logic [5:0]          cursor_col,
   output logic                busy
);

   cons_state_t state, state_nxt;
   logic        clr_pend, clr_pend_nxt;
   logic [8:0]  cnt, cnt_nxt;
   logic [3:0]  row, row_nxt;
   logic [5:0]  col, col_nxt;
   logic        we_nxt;
   logic [8:0]  addr_nxt;
   logic [15:0] data_nxt;

   logic [6:0]  ch;
   logic        accept, is_print, is_lf, is_cr, is_bs, is_ff, wrap;
   logic [3:0]  adv_row, mul_row;
   logic [8:0]  base;

   assign cpu.in_ready = (state == ConsIdle) & ~clr_pend & ~clear;
   assign busy         = (state != ConsIdle) | clr_pend;
   assign cursor_row   = row;
   assign cursor_col   = col;

   assign ch       = cpu.in_char;
   assign accept   = cpu.in_valid & cpu.in_ready;
   assign is_print = accept & (ch >= 7'h20) & (ch <= 7'h7E);
   assign is_lf    = accept & (ch == ChLF);
   assign is_cr    = accept & (ch == ChCR);
   assign is_bs    = accept & (ch == ChBS) & (col != 6'd0);
   assign is_ff    = accept & (ch == ChFF);
   assign wrap     = is_print & (col == 6'(ConsCols - 1));

   assign adv_row = (row == 4'(ConsRows - 1)) ? 4'd0 : row + 4'd1;
   // LF never writes a character, so the one multiplier can serve the new row's first blank.
   assign mul_row = is_lf ? adv_row : row;
   assign base    = row_base(mul_row);

   always_ff @(posedge clk) begin
      if (!rst) state <= ConsIdle;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ConsIdle: begin
            if (clr_pend)            state_nxt = ConsClrAll;
            else if (wrap || is_lf)  state_nxt = ConsClrLine;
         end
         ConsClrLine: if (cnt == 9'(ConsCols))         state_nxt = ConsIdle;
         ConsClrAll:  if (cnt == 9'(ConsLastCell + 1)) state_nxt = ConsIdle;
         default:     state_nxt = ConsIdle;
      endcase
   end

   // cnt holds the next cell to issue; sweeps entered from IDLE issue cell 0 immediately.
   always_comb begin
      we_nxt       = 1'b0;
      addr_nxt     = mem_addr;
      data_nxt     = mem_data;
      cnt_nxt      = cnt;
      row_nxt      = row;
      col_nxt      = col;
      clr_pend_nxt = clr_pend | clear;
      case (state)
         ConsIdle: begin
            if (clr_pend) begin
               we_nxt       = 1'b1;
               addr_nxt     = 9'd0;
               data_nxt     = ConsBlank;
               cnt_nxt      = 9'd1;
               clr_pend_nxt = clear;
            end else if (is_print) begin
               we_nxt   = 1'b1;
               addr_nxt = base + 9'(col);
               data_nxt = {cpu.in_color, ch};
               if (wrap) begin
                  col_nxt = 6'd0;
                  row_nxt = adv_row;
                  cnt_nxt = 9'd0;
               end else begin
                  col_nxt = col + 6'd1;
               end
            end else if (is_lf) begin
               we_nxt   = 1'b1;
               addr_nxt = base;
               data_nxt = ConsBlank;
               cnt_nxt  = 9'd1;
               col_nxt  = 6'd0;
               row_nxt  = adv_row;
            end else if (is_cr) begin
               col_nxt = 6'd0;
            end else if (is_bs) begin
               we_nxt   = 1'b1;
               addr_nxt = base + 9'(col) - 9'd1;
               data_nxt = ConsBlank;
               col_nxt  = col - 6'd1;
            end else if (is_ff) begin
               clr_pend_nxt = 1'b1;
            end
         end
         ConsClrLine: begin
            if (cnt == 9'(ConsCols)) begin
               cnt_nxt = 9'd0;
            end else begin
               we_nxt   = 1'b1;
               addr_nxt = base + cnt;
               data_nxt = ConsBlank;
               cnt_nxt  = cnt + 9'd1;
            end
         end
         ConsClrAll: begin
            if (cnt == 9'(ConsLastCell + 1)) begin
               cnt_nxt = 9'd0;
               row_nxt = 4'd0;
               col_nxt = 6'd0;
            end else begin
               we_nxt   = 1'b1;
               addr_nxt = cnt;
               data_nxt = ConsBlank;
               cnt_nxt  = cnt + 9'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         clr_pend <= 1'b0;
         cnt      <= 9'd0;
         row      <= 4'd0;
         col      <= 6'd0;
         we       <= 1'b0;
         mem_addr <= 9'd0;
         mem_data <= 16'd0;
      end else begin
         clr_pend <= clr_pend_nxt;
         cnt      <= cnt_nxt;
         row      <= row_nxt;
         col      <= col_nxt;
         we       <= we_nxt;
         mem_addr <= addr_nxt;
         mem_data <= data_nxt;
      end
   end

endmodule

// File: tb/tb_vga_console.sv
// Randomized bench for vga_console: a cell-level console model predicts every memory write and the cursor.
module tb_vga_console;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic        we;
   logic [8:0]  mem_addr;
   logic [15:0] mem_data;
   logic [3:0]  cursor_row;
   logic [5:0]  cursor_col;
   logic        busy;

   vga_console_if cpu_if ();

   vga_console dut (
      .clk        (clk),
      .rst        (rst),
      .cpu        (cpu_if),
      .clear      (clear),
      .we         (we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [24:0] exp_q[$];
   logic [24:0] mon_e;
   int          m_row = 0;
   int          m_col = 0;
   int unsigned cyc = 0;
   int unsigned wr_prev = 0;
   int unsigned wr_last = 0;
   int          last_addr = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         wr_prev   = wr_last;
         wr_last   = cyc;
         last_addr = int'(mem_addr);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(mon_e[24:16]));
            check("wr_data", 32'(mem_data), 32'(mon_e[15:0]));
         end
      end
   end

   // Reference console: operates on whole cells and rows, independent of sweep timing.
   task automatic push_wr(input int addr, input logic [15:0] d);
      exp_q.push_back({9'(addr), d});
   endtask

   task automatic m_adv_row();
      m_row = (m_row + 1) % 13;
      for (int i = 0; i < 39; i++) push_wr(m_row * 39 + i, 16'h0020);
   endtask

   task automatic m_full_clear();
      for (int i = 0; i < 507; i++) push_wr(i, 16'h0020);
      m_row = 0;
      m_col = 0;
   endtask

   task automatic m_char(input logic [6:0] ch, input logic [8:0] color);
      if (ch >= 7'h20 && ch <= 7'h7E) begin
         push_wr(m_row * 39 + m_col, {color, ch});
         m_col++;
         if (m_col == 39) begin
            m_col = 0;
            m_adv_row();
         end
      end else if (ch == 7'h0A) begin
         m_col = 0;
         m_adv_row();
      end else if (ch == 7'h0D) begin
         m_col = 0;
      end else if (ch == 7'h08) begin
         if (m_col > 0) begin
            m_col--;
            push_wr(m_row * 39 + m_col, 16'h0020);
         end
      end else if (ch == 7'h0C) begin
         m_full_clear();
      end
   endtask

   // All driver tasks start and end just after a rising edge.
   task automatic send(input logic [6:0] ch, input logic [8:0] color, output int waited);
      cpu_if.in_valid = 1'b1;
      cpu_if.in_char  = ch;
      cpu_if.in_color = color;
      waited = 0;
      @(negedge clk);
      while (cpu_if.in_ready !== 1'b1 && waited < 3000) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 3000) begin
         check("send_timeout", 32'(cpu_if.in_ready), 32'd1);
         cpu_if.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         m_char(ch, color);
         #1;
         cpu_if.in_valid = 1'b0;
      end
   endtask

   task automatic send1(input logic [6:0] ch, input logic [8:0] color);
      int w;
      send(ch, color, w);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      m_full_clear();
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      @(negedge clk);
      while (!(busy === 1'b0 && we === 1'b0 && exp_q.size() == 0) && k < 3000) begin
         k++;
         @(negedge clk);
      end
      check({name, "_idle"}, 32'(k < 3000), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_cursor(input string name);
      check({name, "_row"}, 32'(cursor_row), 32'(m_row));
      check({name, "_col"}, 32'(cursor_col), 32'(m_col));
   endtask

   initial begin
      int w;
      int cnt_bad;
      int r;
      int v;
      logic [6:0] ch;

      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int cnt_bad;
      int r;
      int v;
      logic [6:0] ch;
      logic [8:0] col;

      cpu_if.in_valid = 1'b0;
      cpu_if.in_char  = 7'h00;
      cpu_if.in_color = 9'h000;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_we", 32'(we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_data", 32'(mem_data), 32'd0);
      check("rst_ready", 32'(cpu_if.in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check_cursor("rst");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // "AB" back to back: two consecutive write cycles, no stall on the second char.
      send1(7'h41, 9'h1FF);
      send(7'h42, 9'h1FF, w);
      check("ab_no_stall", 32'(w), 32'd0);
      wait_idle("ab");
      check("ab_consecutive", wr_last - wr_prev, 32'd1);
      check("ab_last_addr", 32'(last_addr), 32'd1);
      check_cursor("ab");

      // Full row of printables from (0,0): wrap and line clear of row 1.
      send1(7'h0D, 9'h000);
      for (int i = 0; i < 39; i++) send1(7'($urandom_range(32, 126)), 9'($urandom_range(0, 511)));
      cnt_bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (cpu_if.in_ready !== 1'b0) cnt_bad++;
      end
      check("line_sweep_ready_low", 32'(cnt_bad), 32'd0);
      @(negedge clk);
      check("ready_after_line_sweep", 32'(cpu_if.in_ready), 32'd1);
      wait_idle("wrap");
      check("wrap_last_addr", 32'(last_addr), 32'd77);
      check_cursor("wrap");

      // Reach (12,5) then LF wraps to row 0 and blanks cells 0..38.
      for (int i = 0; i < 11; i++) send1(7'h0A, 9'h000);
      for (int i = 0; i < 5; i++) send1(7'($urandom_range(32, 126)), 9'($urandom_range(0, 511)));
      wait_idle("row12");
      check_cursor("row12");
      send1(7'h0A, 9'h000);
      wait_idle("lf_wrap");
      check("lf_wrap_last_addr", 32'(last_addr), 32'd38);
      check_cursor("lf_wrap");

      // Backspace at column 0 is a no-op; at column 4 it blanks cell 3*39+3.
      for (int i = 0; i < 3; i++) send1(7'h0A, 9'h000);
      wait_idle("bs_setup");
      send1(7'h08, 9'h000);
      wait_idle("bs_col0");
      check_cursor("bs_col0");
      for (int i = 0; i < 4; i++) send1(7'($urandom_range(32, 126)), 9'($urandom_range(0, 511)));
      send1(7'h08, 9'h000);
      wait_idle("bs");
      check("bs_addr", 32'(last_addr), 32'd120);
      check_cursor("bs");

      // clear beats in_valid in the same cycle; a second clear mid-sweep adds a full sweep.
      cpu_if.in_valid = 1'b1;
      cpu_if.in_char  = 7'h5A;
      cpu_if.in_color = 9'h1FF;
      clear = 1'b1;
      @(negedge clk);
      check("clear_blocks_ready", 32'(cpu_if.in_ready), 32'd0);
      @(posedge clk);
      m_full_clear();
      #1;
      clear = 1'b0;
      cpu_if.in_valid = 1'b0;
      cnt_bad = 0;
      repeat (250) begin
         @(negedge clk);
         if (busy !== 1'b1) cnt_bad++;
      end
      @(posedge clk);
      #1;
      pulse_clear();
      repeat (700) begin
         @(negedge clk);
         if (busy !== 1'b1) cnt_bad++;
      end
      check("full_sweep_busy", 32'(cnt_bad), 32'd0);
      wait_idle("full");
      check("full_last_addr", 32'(last_addr), 32'd506);
      check_cursor("full");

      // Random mix of printables, control codes, ignored codes and clear pulses.
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      ch = 7'($urandom_range(32, 126));
         else if (r < 78) ch = 7'h0A;
         else if (r < 84) ch = 7'h0D;
         else if (r < 90) ch = 7'h08;
         else if (r < 92) ch = 7'h0C;
         else begin
            v  = $urandom_range(0, 32);
            ch = (v == 32) ? 7'h7F : 7'(v);
            if (ch == 7'h0A || ch == 7'h0D || ch == 7'h08 || ch == 7'h0C) ch = 7'h00;
         end
         if (r >= 97) pulse_clear();
         else         send1(ch, 9'($urandom_range(0, 511)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         if (i % 25 == 24) begin
            wait_idle("rand");
            check_cursor("rand");
         end
      end

      // Reset in the middle of a full clear aborts it at once.
      send1(7'h41, 9'h0AA);
      wait_idle("pre_rst");
      pulse_clear();
      w = 0;
      @(negedge clk);
      while (!(we === 1'b1 && mem_addr == 9'd200) && w < 1000) begin
         w++;
         @(negedge clk);
      end
      check("reach_cell_200", 32'(w < 1000), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      @(negedge clk);
      check("midrst_we", 32'(we), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(cpu_if.in_ready), 32'd1);
      check_cursor("midrst");
      rst = 1'b1;
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1;
      send1(7'h43, 9'h1FF);
      wait_idle("post_rst");
      check("post_rst_addr", 32'(last_addr), 32'd0);
      check_cursor("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
